// File: rtl/mc_sched_pkg.sv
// Shared types and scoring constants for the request issue scheduler.
// Class weights, entry layout and FSM states live here so the top and argmax agree.
package mc_sched_pkg;

  localparam int SCORE_W    = 8;
  localparam int DEF_AGE_W  = 6;
  localparam int DEF_ADDR_W = 32;

  localparam logic [SCORE_W-1:0] W_CLASS3 = 8'd128;
  localparam logic [SCORE_W-1:0] W_CLASS2 = 8'd8;
  localparam logic [SCORE_W-1:0] W_CLASS1 = 8'd2;
  localparam logic [SCORE_W-1:0] W_TURN   = 8'd4;

  typedef struct packed {
    logic                  valid;
    logic                  rw;
    logic [2:0]            cls;
    logic [DEF_AGE_W-1:0]  age;
    logic [DEF_ADDR_W-1:0] addr;
  } sched_entry_t;

  typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} sched_state_t;

  // Age-independent part of the score: row/bank class weight plus turnaround bonus.
  function automatic logic [SCORE_W-1:0] class_weight(input logic [2:0] cls);
    logic [SCORE_W-1:0] w;
    case (cls[2:1])
      2'b11:   w = W_CLASS3;
      2'b10:   w = W_CLASS2;
      2'b01:   w = W_CLASS1;
      default: w = '0;
    endcase
    if (cls[0]) w = w + W_TURN;
    return w;
  endfunction

endpackage

// File: rtl/sched_max_tree.sv
// Combinational argmax over the eligible slots; ties resolve to the lowest index.
// With STARVE_GUARD_EN defined, the lowest-index saturated eligible slot overrides the score.
module sched_max_tree
  import mc_sched_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]              eligible,
  input  logic [DEPTH-1:0][SCORE_W-1:0] score,
  input  logic [DEPTH-1:0]              saturated,
  output logic [IDX_W-1:0]              win_idx,
  output logic                          any_eligible
);

  logic [SCORE_W-1:0] best_score;
  logic [IDX_W-1:0]   score_idx;
  logic               starve_hit;
  logic [IDX_W-1:0]   starve_idx;

  // Strict greater-than keeps the earlier (lower) index on equal scores.
  always_comb begin
    best_score   = '0;
    score_idx    = '0;
    any_eligible = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (eligible[i] && (!any_eligible || score[i] > best_score)) begin
        any_eligible = 1'b1;
        best_score   = score[i];
        score_idx    = IDX_W'(i);
      end
    end
  end

`ifdef STARVE_GUARD_EN
  always_comb begin
    starve_hit = 1'b0;
    starve_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!starve_hit && eligible[i] && saturated[i]) begin
        starve_hit = 1'b1;
        starve_idx = IDX_W'(i);
      end
    end
  end
`else
  logic unused_saturated;
  assign unused_saturated = ^saturated;
  assign starve_hit       = 1'b0;
  assign starve_idx       = '0;
`endif

  assign win_idx = starve_hit ? starve_idx : score_idx;

endmodule

// File: rtl/req_issue_scheduler.sv
// Ageing request scheduler: DEPTH slots scored by class and age, best one issued to the command stage.
// Optional starvation guard is enabled by defining STARVE_GUARD_EN.
module req_issue_scheduler
  import mc_sched_pkg::*;
#(
  parameter  int DEPTH  = 16,
  parameter  int AGE_W  = 6,
  parameter  int ADDR_W = 32,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [ADDR_W-1:0] enq_addr,
  input  logic              enq_rw,
  input  logic [2:0]        enq_class,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [ADDR_W-1:0] iss_addr,
  output logic              iss_rw,
  output logic [IDX_W-1:0]  iss_idx,
  output logic [IDX_W:0]    occupancy,
  output sched_state_t      fsm_state
);

  localparam logic [AGE_W-1:0] AGE_MAX  = '1;
  localparam logic [IDX_W:0]   OCC_FULL = (IDX_W+1)'(DEPTH);

  logic [DEPTH-1:0]  slot_valid;
  logic [DEPTH-1:0]  slot_rw;
  logic [2:0]        slot_class [DEPTH];
  logic [AGE_W-1:0]  slot_age   [DEPTH];
  logic [ADDR_W-1:0] slot_addr  [DEPTH];

  sched_state_t                  state;
  logic [DEPTH-1:0]              eligible;
  logic [DEPTH-1:0]              saturated;
  logic [DEPTH-1:0][SCORE_W-1:0] score;
  logic [IDX_W-1:0]              win_idx;
  logic [IDX_W-1:0]              free_idx;
  logic                          any_eligible;
  logic                          enq_fire;
  logic                          iss_fire;
  logic                          load_win;

  // Both sides: a transfer happens exactly on an edge where valid and ready are both high;
  // the offering side keeps its payload stable until then, ready never depends on same-cycle valid.
  assign enq_ready = (occupancy != OCC_FULL);
  assign enq_fire  = enq_valid && enq_ready;
  assign iss_fire  = iss_valid && iss_ready;
  assign load_win  = any_eligible && ((state == S_IDLE) || iss_fire);
  assign fsm_state = state;

  always_comb begin
    eligible  = '0;
    saturated = '0;
    score     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      eligible[i]  = slot_valid[i] && !((state == S_HOLD) && (iss_idx == IDX_W'(i)));
      saturated[i] = (slot_age[i] == AGE_MAX);
      score[i]     = eligible[i] ? class_weight(slot_class[i]) + SCORE_W'(slot_age[i]) : '0;
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!slot_valid[i]) free_idx = IDX_W'(i);
    end
  end

  sched_max_tree #(.DEPTH(DEPTH)) u_max_tree (
    .eligible    (eligible),
    .score       (score),
    .saturated   (saturated),
    .win_idx     (win_idx),
    .any_eligible(any_eligible)
  );

  // Eligibility comes from registered state, so a slot enqueued at this edge cannot win this edge,
  // and the free slot chosen for enqueue is never the held or the winning slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_valid <= '0;
      slot_rw    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_class[i] <= '0;
        slot_age[i]   <= '0;
        slot_addr[i]  <= '0;
      end
      state     <= S_IDLE;
      iss_valid <= 1'b0;
      iss_addr  <= '0;
      iss_rw    <= 1'b0;
      iss_idx   <= '0;
      occupancy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (eligible[i] && (slot_age[i] != AGE_MAX)) slot_age[i] <= slot_age[i] + AGE_W'(1);
      end

      if (iss_fire) begin
        slot_valid[iss_idx] <= 1'b0;
        slot_age[iss_idx]   <= '0;
      end

      if (enq_fire) begin
        slot_valid[free_idx] <= 1'b1;
        slot_rw[free_idx]    <= enq_rw;
        slot_class[free_idx] <= enq_class;
        slot_age[free_idx]   <= '0;
        slot_addr[free_idx]  <= enq_addr;
      end

      if (load_win) begin
        state     <= S_HOLD;
        iss_valid <= 1'b1;
        iss_addr  <= slot_addr[win_idx];
        iss_rw    <= slot_rw[win_idx];
        iss_idx   <= win_idx;
      end else if (iss_fire) begin
        state     <= S_IDLE;
        iss_valid <= 1'b0;
      end

      case ({enq_fire, iss_fire})
        2'b10:   occupancy <= occupancy + (IDX_W+1)'(1);
        2'b01:   occupancy <= occupancy - (IDX_W+1)'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: tb/tb_req_issue_scheduler.sv
// Directed bench for req_issue_scheduler: issued requests are checked against an expected queue.
// Expected issue orders depend on whether STARVE_GUARD_EN is defined.
module tb_req_issue_scheduler;
  import mc_sched_pkg::*;

  localparam int DEPTH  = 16;
  localparam int IDX_W  = 4;
  localparam int ADDR_W = 32;
  localparam int EW     = 1 + IDX_W + ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              enq_valid;
  logic              enq_ready;
  logic [ADDR_W-1:0] enq_addr;
  logic              enq_rw;
  logic [2:0]        enq_class;
  logic              iss_valid;
  logic              iss_ready;
  logic [ADDR_W-1:0] iss_addr;
  logic              iss_rw;
  logic [IDX_W-1:0]  iss_idx;
  logic [IDX_W:0]    occupancy;
  sched_state_t      fsm_state;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_got;
  logic [EW-1:0] mon_exp;
  int            n_checks = 0;
  int            n_pass   = 0;
  int            order[8];

  req_issue_scheduler #(.DEPTH(DEPTH), .AGE_W(6), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enq_valid(enq_valid),
    .enq_ready(enq_ready),
    .enq_addr (enq_addr),
    .enq_rw   (enq_rw),
    .enq_class(enq_class),
    .iss_valid(iss_valid),
    .iss_ready(iss_ready),
    .iss_addr (iss_addr),
    .iss_rw   (iss_rw),
    .iss_idx  (iss_idx),
    .occupancy(occupancy),
    .fsm_state(fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every handshake pops one expected {rw, idx, addr}
  always @(negedge clk) begin
    if (rst_n && iss_valid && iss_ready) begin
      mon_got = {iss_rw, iss_idx, iss_addr};
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL issue_unexpected: got %h, required no issue", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got === mon_exp) n_pass++;
        else $display("FAIL issue_order: got %h, required %h", mon_got, mon_exp);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    n_checks++;
    if (got === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, got, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    enq_valid = 1'b0;
    enq_addr  = '0;
    enq_rw    = 1'b0;
    enq_class = '0;
    iss_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic enq(input logic [ADDR_W-1:0] addr, input logic rw, input logic [2:0] cls);
    enq_valid = 1'b1;
    enq_addr  = addr;
    enq_rw    = rw;
    enq_class = cls;
    tick();
    enq_valid = 1'b0;
  endtask

  task automatic push_exp(input logic rw, input int idx, input logic [ADDR_W-1:0] addr);
    exp_q.push_back({rw, IDX_W'(idx), addr});
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    do_reset();

    // Reset state, then single-request latency
    check("rst_iss_valid", iss_valid, 0);
    check("rst_enq_ready", enq_ready, 1);
    check("rst_occupancy", occupancy, 0);
    check("rst_iss_addr", iss_addr, 0);
    check("rst_iss_idx", iss_idx, 0);
    check("rst_fsm_state", fsm_state, S_IDLE);
    enq(32'h100, 1'b0, 3'b110);
    check("t1_valid_edge_n", iss_valid, 0);
    check("t1_occupancy", occupancy, 1);
    tick();
    check("t1_valid_edge_n1", iss_valid, 1);
    check("t1_addr", iss_addr, 32'h100);
    check("t1_idx", iss_idx, 0);
    push_exp(1'b0, 0, 32'h100);
    iss_ready = 1'b1;
    wait_drain("t1_drain", 10);
    iss_ready = 1'b0;
    check("t1_valid_after", iss_valid, 0);
    check("t1_occ_after", occupancy, 0);

    // Held request A, then back-to-back B
    do_reset();
    enq(32'h200, 1'b1, 3'b010);
    enq(32'h300, 1'b0, 3'b110);
    check("t2_held_valid", iss_valid, 1);
    check("t2_held_idx", iss_idx, 0);
    repeat (2) tick();
    check("t2_held_stable", iss_addr, 32'h200);
    push_exp(1'b1, 0, 32'h200);
    push_exp(1'b0, 1, 32'h300);
    iss_ready = 1'b1;
    tick();
    check("t2_b2b_valid", iss_valid, 1);
    check("t2_b2b_idx", iss_idx, 1);
    wait_drain("t2_drain", 10);
    iss_ready = 1'b0;
    check("t2_valid_after", iss_valid, 0);
    check("t2_occ_after", occupancy, 0);

    // Full scheduler, one issue frees a slot
    do_reset();
    for (int i = 0; i < DEPTH; i++) enq(32'h1000 + 32'(i * 16), 1'(i), 3'b000);
    check("t3_full_occ", occupancy, 16);
    check("t3_full_ready", enq_ready, 0);
    push_exp(1'b0, 0, 32'h1000);
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
    check("t3_ready_after", enq_ready, 1);
    check("t3_occ_after", occupancy, 15);
    check("t3_next_idx", iss_idx, 1);
    check("t3_popped", exp_q.size(), 0);

    // Equal class and age in slots 3 and 7
    do_reset();
    for (int i = 0; i < 8; i++) enq(32'h400 + 32'(i * 4), 1'b0, (i == 3 || i == 7) ? 3'b100 : 3'b000);
    repeat (80) tick();
`ifdef STARVE_GUARD_EN
    order = '{0, 1, 2, 3, 4, 5, 6, 7};
`else
    order = '{0, 3, 7, 1, 2, 4, 5, 6};
`endif
    for (int k = 0; k < 8; k++) push_exp(1'b0, order[k], 32'h400 + 32'(order[k] * 4));
    iss_ready = 1'b1;
    wait_drain("t4_drain", 40);
    iss_ready = 1'b0;
    check("t4_occ_after", occupancy, 0);

    // Starved class-001 request against a fresh class-110 one
    do_reset();
    enq(32'h500, 1'b0, 3'b000);
    enq(32'h504, 1'b1, 3'b001);
    repeat (70) tick();
    enq(32'h508, 1'b0, 3'b110);
    tick();
    push_exp(1'b0, 0, 32'h500);
`ifdef STARVE_GUARD_EN
    push_exp(1'b1, 1, 32'h504);
    push_exp(1'b0, 2, 32'h508);
`else
    push_exp(1'b0, 2, 32'h508);
    push_exp(1'b1, 1, 32'h504);
`endif
    iss_ready = 1'b1;
    wait_drain("t5_drain", 20);
    iss_ready = 1'b0;

    // Reset while a request is held
    do_reset();
    enq(32'h600, 1'b0, 3'b110);
    enq(32'h604, 1'b0, 3'b000);
    tick();
    check("t6_pre_valid", iss_valid, 1);
    rst_n = 1'b0;
    tick();
    check("t6_valid", iss_valid, 0);
    check("t6_occ", occupancy, 0);
    check("t6_ready", enq_ready, 1);
    check("t6_fsm_state", fsm_state, S_IDLE);
    rst_n = 1'b1;
    enq(32'h700, 1'b1, 3'b000);
    tick();
    check("t6_reuse_idx", iss_idx, 0);
    check("t6_reuse_occ", occupancy, 1);
    push_exp(1'b1, 0, 32'h700);
    iss_ready = 1'b1;
    wait_drain("t6_drain", 10);
    iss_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
